// File: rtl/stream_threshold_if.sv
// Handshake bundle for stream_threshold.
// Pixel input stream plus thresholded output stream with position flags.
interface stream_threshold_if #(
  parameter int PW = 24
);
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;
  logic          m_eof;

  modport master (
    output s_valid,
    output s_data,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data,
    input  m_sof,
    input  m_eol,
    input  m_eof
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data,
    output m_sof,
    output m_eol,
    output m_eof
  );
endinterface

// File: rtl/stream_threshold.sv
// Two-stage per-pixel threshold with frame-latched config.
// THRESHOLD_FGCOUNT_EN adds a per-frame foreground counter.
module stream_threshold #(
  parameter int DATA_W        = 8,
  parameter int CHANNELS      = 3,
  parameter int WIDTH         = 512,
  parameter int HEIGHT        = 768,
  parameter int THRESHOLD_DEF = 90
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cfg_thr,
  input  logic [1:0]        cfg_mode,
`ifdef THRESHOLD_FGCOUNT_EN
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] fg_count,
  output logic              fg_done,
`endif
  stream_threshold_if.slave bus
);
  localparam int SW = DATA_W + 2;
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [DATA_W-1:0] MAX = '1;

  logic              adv;
  logic              acc;
  logic              first;
  logic              last_x;
  logic              last_y;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [DATA_W-1:0] thr_q;
  logic [1:0]        mode_q;
  logic [SW-1:0]     sum;

  logic              v1;
  logic              sof1;
  logic              eol1;
  logic              eof1;
  logic [SW-1:0]     sum1;
  logic [DATA_W-1:0] thr1;
  logic [1:0]        mode1;

  logic [DATA_W-1:0] mean;
  logic [DATA_W-1:0] res;
  logic              fg;

  assign adv         = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = adv;
  assign acc         = bus.s_valid && adv;
  assign first       = (x == '0) && (y == '0);
  assign last_x      = (x == XW'(WIDTH - 1));
  assign last_y      = (y == YW'(HEIGHT - 1));

  always_comb begin
    sum = '0;
    for (int c = 0; c < CHANNELS; c++)
      sum = sum + SW'(bus.s_data[c*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (acc) begin
      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q  <= DATA_W'(THRESHOLD_DEF);
      mode_q <= '0;
    end else if (acc && first) begin
      thr_q  <= cfg_thr;
      mode_q <= cfg_mode;
    end
  end

  // The frame's first pixel bypasses the shadow so it sees the new config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      sof1  <= 1'b0;
      eol1  <= 1'b0;
      eof1  <= 1'b0;
      sum1  <= '0;
      thr1  <= '0;
      mode1 <= '0;
    end else if (adv) begin
      v1    <= bus.s_valid;
      sof1  <= first;
      eol1  <= last_x;
      eof1  <= last_x && last_y;
      sum1  <= sum;
      thr1  <= first ? cfg_thr : thr_q;
      mode1 <= first ? cfg_mode : mode_q;
    end
  end

  assign mean = DATA_W'(sum1 / SW'(CHANNELS));
  assign fg   = mean > thr1;

  always_comb begin
    res = '0;
    unique case (mode1)
      2'd0: res = fg ? MAX : '0;
      2'd1: res = fg ? '0 : MAX;
      2'd2: res = fg ? thr1 : mean;
      2'd3: res = fg ? mean : '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_sof   <= 1'b0;
      bus.m_eol   <= 1'b0;
      bus.m_eof   <= 1'b0;
    end else if (adv) begin
      bus.m_valid <= v1;
      bus.m_data  <= {CHANNELS{res}};
      bus.m_sof   <= v1 && sof1;
      bus.m_eol   <= v1 && eol1;
      bus.m_eof   <= v1 && eof1;
    end
  end

`ifdef THRESHOLD_FGCOUNT_EN
  localparam int CW = $clog2(WIDTH*HEIGHT+1);

  logic          fg2;
  logic          xfer;
  logic [CW-1:0] run;

  assign xfer = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fg2 <= 1'b0;
    else if (adv)
      fg2 <= v1 && fg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= '0;
      fg_count <= '0;
      fg_done  <= 1'b0;
    end else begin
      fg_done <= xfer && bus.m_eof;
      if (xfer && bus.m_eof) begin
        fg_count <= run + CW'(fg2);
        run      <= '0;
      end else if (xfer && fg2) begin
        run <= run + CW'(1);
      end
    end
  end
`endif
endmodule

// File: tb/tb_stream_threshold.sv
// Randomised scoreboard bench for stream_threshold (4x2 frame).
// Define THRESHOLD_FGCOUNT_EN to also check the foreground counter.
module tb_stream_threshold;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int PW = 24;

  typedef struct {
    logic [23:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] cfg_thr;
  logic [1:0] cfg_mode;
  bit         rand_rdy = 1'b0;
  bit         rdy_force = 1'b1;
  bit         rec = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         fg_pulses = 0;

  exp_t       q[$];
  int         fgq[$];
  int         tq[$];
  int         m_idx = 0;
  int         m_fg = 0;
  logic [7:0] m_thr = 8'd90;
  logic [1:0] m_mode = 2'd0;

  stream_threshold_if #(.PW(PW)) bus ();

`ifdef THRESHOLD_FGCOUNT_EN
  logic [3:0] fg_count;
  logic       fg_done;
`endif

  stream_threshold #(
    .DATA_W(8),
    .CHANNELS(3),
    .WIDTH(W),
    .HEIGHT(H),
    .THRESHOLD_DEF(90)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_thr(cfg_thr),
    .cfg_mode(cfg_mode),
`ifdef THRESHOLD_FGCOUNT_EN
    .fg_count(fg_count),
    .fg_done(fg_done),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: frame index arithmetic and the threshold rules.
  task automatic model_push(input logic [7:0] a,
                            input logic [7:0] b,
                            input logic [7:0] c);
    exp_t       e;
    int         mean;
    bit         f;
    logic [7:0] v;
    if (m_idx == 0) begin
      m_thr  = cfg_thr;
      m_mode = cfg_mode;
    end
    mean = (int'(a) + int'(b) + int'(c)) / 3;
    f = mean > int'(m_thr);
    case (m_mode)
      2'd0:    v = f ? 8'hFF : 8'h00;
      2'd1:    v = f ? 8'h00 : 8'hFF;
      2'd2:    v = f ? m_thr : 8'(mean);
      default: v = f ? 8'(mean) : 8'h00;
    endcase
    e.d   = {v, v, v};
    e.sof = (m_idx == 0);
    e.eol = ((m_idx % W) == W - 1);
    e.eof = (m_idx == W * H - 1);
    q.push_back(e);
    if (f) m_fg++;
    if (e.eof) begin
      fgq.push_back(m_fg);
      m_fg = 0;
    end
    m_idx = (m_idx + 1) % (W * H);
  endtask

  task automatic send(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] c);
    bit ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = {c, b, a};
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 1);
    if (ok) model_push(a, b, c);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_left", q.size(), 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_s_ready"}, 32'(bus.s_ready), 1);
    check({nm, "_m_valid"}, 32'(bus.m_valid), 0);
    check({nm, "_m_data"}, 32'(bus.m_data), 0);
    check({nm, "_flags"},
          32'({bus.m_sof, bus.m_eol, bus.m_eof}), 0);
  endtask

  // Asserted between edges to exercise the asynchronous path.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst");
    q.delete();
    fgq.delete();
    m_idx  = 0;
    m_fg   = 0;
    m_thr  = 8'd90;
    m_mode = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = rand_rdy ? ($urandom_range(0, 3) != 0)
                             : rdy_force;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (rec) tq.push_back(cyc);
      if (q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("m_data", 32'(bus.m_data), 32'(e.d));
        check("m_flags",
              32'({bus.m_sof, bus.m_eol, bus.m_eof}),
              32'({e.sof, e.eol, e.eof}));
      end
    end
  end

`ifdef THRESHOLD_FGCOUNT_EN
  always @(negedge clk) begin
    if (rst_n && fg_done) begin
      fg_pulses++;
      if (fgq.size() == 0)
        check("fg_done_spurious", 1, 0);
      else
        check("fg_count", 32'(fg_count), fgq.pop_front());
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d pending",
             q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int span;
    int base;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    cfg_thr     = 8'd90;
    cfg_mode    = 2'd0;

    do_reset();
    @(negedge clk);
    check_idle_outputs("idle");
`ifdef THRESHOLD_FGCOUNT_EN
    check("fg_count_rst", 32'(fg_count), 0);
    check("fg_done_rst", 32'(fg_done), 0);
`endif
    @(posedge clk);
    #1;

    send(93, 91, 90);
    @(negedge clk);
    check("lat_cycle1_valid", 32'(bus.m_valid), 0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(bus.m_valid), 1);
    check("lat_cycle2_data", 32'(bus.m_data), 32'hFFFFFF);
    @(posedge clk);
    #1;
    send(100, 90, 80);
    send(93, 91, 90);
    repeat (5) send_rand();
    wait_drain();

    cfg_mode = 2'd1;
    tq.delete();
    rec = 1'b1;
    send(100, 90, 80);
    send(93, 91, 90);
    repeat (6) send_rand();
    wait_drain();
    rec = 1'b0;
    check("b2b_count", tq.size(), 8);
    if (tq.size() == 8) begin
      span = tq[7] - tq[0];
      check("b2b_span", span, 7);
    end

    for (int md = 2; md < 4; md++) begin
      cfg_mode = 2'(md);
      send(200, 200, 200);
      send(30, 30, 30);
      repeat (6) send_rand();
    end
    wait_drain();

    cfg_mode = 2'd0;
    cfg_thr  = 8'd90;
    send(150, 150, 150);
    send_rand();
    send_rand();
    cfg_thr = 8'd200;
    send(150, 150, 150);
    repeat (4) send_rand();
    send(210, 210, 210);
    send(150, 150, 150);
    repeat (6) send_rand();
    wait_drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        cfg_thr  = 8'($urandom);
        cfg_mode = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 3));
      send_rand();
    end
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wait_drain();

    rdy_force = 1'b0;
    @(posedge clk);
    #2;
    send(50, 60, 70);
    send(120, 130, 140);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.m_valid), 1);
      check("stall_s_ready", 32'(bus.s_ready), 0);
      if (q.size() != 0)
        check("stall_data", 32'(bus.m_data), 32'(q[0].d));
    end
    rdy_force = 1'b1;
    send(10, 20, 30);
    wait_drain();

    cfg_thr  = 8'd90;
    cfg_mode = 2'd0;
    send_rand();
    send_rand();
    send_rand();
    do_reset();
    base = fg_pulses;
    send(200, 200, 200);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m_valid) break;
    end
    check("post_rst_sof", 32'(bus.m_sof), 1);
    @(posedge clk);
    #1;
    repeat (4) send(200, 200, 200);
    repeat (3) send(10, 10, 10);
    wait_drain();
    repeat (3) @(posedge clk);
`ifdef THRESHOLD_FGCOUNT_EN
    check("fg_pulse_count", fg_pulses - base, 1);
    check("fg_count_final", 32'(fg_count), 5);
    check("fgq_left", fgq.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
